// File: rtl/mem_access_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around the memory arbiter.
// No latency of its own; plain wires between the requesters, the arbiter and the memory.
// No backpressure; requests are held levels and completion is a one-cycle pulse.
interface mem_access_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  // load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  // memory side and freeze status
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [2:0]        mem_state;

  // arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_done, d_rdata, d_done,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_state
  );

  // requesters plus memory side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_done, d_rdata, d_done,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_state
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Shares one fixed-latency memory between fetch and load/store, one access at a time.
// Latency: MEM_LAT BUSY cycles after the sampling IDLE cycle, done pulse in cycle MEM_LAT+1.
// Backpressure: losing requester just holds req; mem_state=111 freezes the CPU while BUSY.
module mem_access_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 4
) (
  input logic                 clk,
  input logic                 rst,
  mem_access_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY     = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  logic [1:0] state;
  logic       gnt;        // owner of the access in flight: 0 fetch, 1 data
  logic [1:0] d_streak;   // data grants in a row while fetch was waiting
  logic [3:0] cnt;        // BUSY cycles remaining after the current one
  logic       start;
  logic       grant_d;
  logic       busy_last;

  // Arbitration: data wins unless fetch has already been passed over twice in a row
  always_comb begin
    start     = (state == IDLE) && (bus.if_req || bus.d_req);
    grant_d   = bus.d_req && !(bus.if_req && (d_streak == 2'd2));
    busy_last = (state == BUSY) && (cnt == 4'd0);
  end

  // Sequencer: IDLE -> BUSY (MEM_LAT cycles) -> DONE -> IDLE, plus fairness streak
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      d_streak <= 2'd0;
      cnt      <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= BUSY;
            cnt      <= CNT_LOAD;
            gnt      <= grant_d;
            d_streak <= (grant_d && bus.if_req) ? d_streak + 2'd1 : 2'd0;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory port: strobe once on entry, hold command for the whole access, status tracks BUSY
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.mem_state <= 3'b000;
    end else begin
      bus.mem_en <= start;
      if (start) begin
        bus.mem_state <= 3'b111;
        bus.mem_we    <= grant_d && bus.d_we;
        bus.mem_addr  <= grant_d ? bus.d_addr : bus.if_addr;
        bus.mem_wdata <= grant_d ? bus.d_wdata : {DATA_W{1'b0}};
      end else if (busy_last) begin
        bus.mem_state <= 3'b000;
      end
    end
  end

  // Response: capture read data in the last BUSY cycle and pulse done to the owner
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.if_rdata <= {DATA_W{1'b0}};
      bus.d_rdata  <= {DATA_W{1'b0}};
      bus.if_done  <= 1'b0;
      bus.d_done   <= 1'b0;
    end else begin
      bus.if_done <= busy_last && !gnt;
      bus.d_done  <= busy_last && gnt;
      if (busy_last && !gnt) begin
        bus.if_rdata <= bus.mem_rdata;
      end
      // stores leave the load data register untouched
      if (busy_last && gnt && !bus.mem_we) begin
        bus.d_rdata <= bus.mem_rdata;
      end
    end
  end
endmodule
